imem_loader: RTL and testbench

//  Byte-stream program loader that builds the 32-bit instruction words whose

---
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
//
// Takes program bytes from a valid/ready byte stream, assembles them
// little-endian into 32-bit instruction words and writes each word to the
// instruction memory, starting at word 0. The core is held in stall while a
// load is in progress. Any word whose low two bits are not 2'b11 (not a 32-bit
// RV encoding) raises a sticky error flag; such words are still written.
//
// Parameters:
//   ADDR_W      imem word-address width; capacity is 2**ADDR_W words
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       1-cycle pulse, begins a load (only honoured when idle)
//   num_words   number of words to load, sampled on an accepted start
//   byte_valid  byte_data carries a valid byte
//   byte_data   next program byte, least-significant byte of a word first
//   byte_ready  loader accepts a byte this cycle
//   imem_we     imem write strobe, one cycle per word
//   imem_addr   imem word address
//   imem_wdata  assembled instruction word
//   cpu_hold    core stall request while loading
//   done        1-cycle pulse when the load has finished
//   err         sticky flag: a loaded word had opcode[1:0] != 2'b11
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

  // Memory capacity in words; num_words is one bit wider so it can exceed it.
  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OneWord  = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q;
  logic [ADDR_W:0] n_words_q;  // clamped word count for the current load
  logic [1:0]      lane_q;     // byte lane of the next accepted byte
  logic [23:0]     asm_q;      // lanes 0..2 of the word being assembled

  logic [ADDR_W:0] n_clamped;
  logic            last_word;

  // Clamping the count guarantees the address never wraps past the top word.
  assign n_clamped = (num_words > MaxWords) ? MaxWords : num_words;

  // Only evaluated in StWrite, where n_words_q is at least 1.
  assign last_word = ({1'b0, imem_addr} == (n_words_q - OneWord));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_words_q  <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Strobes default low; set only on the transition into their state.
      imem_we <= 1'b0;
      done    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_words_q <= n_clamped;
            lane_q    <= '0;
            imem_addr <= '0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
            if (n_clamped == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q    <= StLoad;
              byte_ready <= 1'b1;
            end
          end
        end

        StLoad: begin
          // byte_ready is high throughout this state, so valid alone transfers.
          if (byte_valid) begin
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                // Fourth byte completes the word; present it with the strobe.
                imem_wdata <= {byte_data, asm_q};
                imem_we    <= 1'b1;
                byte_ready <= 1'b0;
                state_q    <= StWrite;
              end
            endcase
          end
        end

        StWrite: begin
          if (imem_wdata[1:0] != 2'b11) begin
            err <= 1'b1;
          end
          if (last_word) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            imem_addr  <= imem_addr + 1'b1;
            byte_ready <= 1'b1;
            state_q    <= StLoad;
          end
        end

        StDone: begin
          cpu_hold <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          state_q    <= StIdle;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            done_cnt = 0;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write and done log, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) step();
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i <= 40; i++) begin
      if (byte_ready === 1'b1) begin
        step();
        byte_valid = 1'b0;
        return;
      end
      step();
    end
    byte_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_byte_timeout byte_ready got 0 want 1");
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = (AW+1)'(n);
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    for (cyc = 0; cyc < 20; cyc++) begin
      if (done === 1'b1) return;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_byte_ready got %b want 0", byte_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we got %b want 0", imem_we); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_imem_addr got %0h want 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_imem_wdata got %0h want 0", imem_wdata); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_cpu_hold got %b want 0", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
  endtask

  task automatic test_single_word();
    wa.delete(); wd.delete();
    do_start(1);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL t1_hold got %b want 1", cpu_hold); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL t1_ready got %b want 1", byte_ready); end
    send_byte(8'h37, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL t1_we got %b want 1", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL t1_addr got %0h want 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h00000537) begin errors++; $display("FAIL t1_wdata got %0h want 537", imem_wdata); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_wr got %b want 0", byte_ready); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done got %b want 1", done); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL t1_we_off got %b want 0", imem_we); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_err got %b want 0", err); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL t1_hold_done got %b want 1", cpu_hold); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_off got %b want 0", done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL t1_hold_off got %b want 0", cpu_hold); end
    checks++; if (imem_wdata !== 32'h00000537) begin errors++; $display("FAIL t1_wdata_hold got %0h want 537", imem_wdata); end
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL t1_nwrites got %0d want 1", wa.size()); end
  endtask

  task automatic test_gaps();
    int cyc;
    wa.delete(); wd.delete();
    do_start(2);
    send_word(32'h0000006F, 2);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL t2_hold_w0 got %b want 1", cpu_hold); end
    send_word(32'h00000017, 3);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL t2_hold_w1 got %b want 1", cpu_hold); end
    wait_done(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL t2_done_lat got %0d want 1", cyc); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL t2_hold_done got %b want 1", cpu_hold); end
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL t2_nwrites got %0d want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[0] !== 8'h00 || wa[1] !== 8'h01) begin errors++; $display("FAIL t2_addrs got %0h,%0h want 0,1", wa[0], wa[1]); end
      checks++; if (wd[0] !== 32'h6F || wd[1] !== 32'h17) begin errors++; $display("FAIL t2_data got %0h,%0h want 6f,17", wd[0], wd[1]); end
    end
    step();
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL t2_hold_off got %b want 0", cpu_hold); end
  endtask

  task automatic test_err();
    wa.delete(); wd.delete();
    do_start(2);
    send_word(32'h00000013, 0);
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t3_err_w0 got %b want 0", err); end
    send_word(32'h00000010, 0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t3_err_pre got %b want 0", err); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_err_set got %b want 1", err); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_done got %b want 1", done); end
    step();
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_err_sticky got %b want 1", err); end
    checks++; if (wd.size() !== 2 || wd[1] !== 32'h10) begin errors++; $display("FAIL t3_w1 got n=%0d want 2 words", wd.size()); end
  endtask

  task automatic test_reset_mid_load();
    wa.delete(); wd.delete();
    do_start(2);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_err_clr got %b want 0", err); end
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 || imem_we !== 1'b0)
      begin errors++; $display("FAIL t4_rst_ctl got r%b h%b d%b w%b want 0000", byte_ready, cpu_hold, done, imem_we); end
    checks++; if (imem_addr !== '0 || imem_wdata !== 32'h0 || err !== 1'b0)
      begin errors++; $display("FAIL t4_rst_data got a%0h d%0h e%b want 0", imem_addr, imem_wdata, err); end
    step();
    step();
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL t4_no_write got %0d want 0", wa.size()); end
    do_start(1);
    send_word(32'h00002083, 0);
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL t4_addr got %0h want 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h00002083) begin errors++; $display("FAIL t4_wdata got %0h want 2083", imem_wdata); end
    step();
    step();
  endtask

  task automatic test_bounds();
    int cyc;
    int seq_bad;
    wa.delete(); wd.delete();
    do_start(0);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b0)
      begin errors++; $display("FAIL t5_zero_done got d%b h%b r%b want 1 1 0", done, cpu_hold, byte_ready); end
    step();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL t5_zero_idle got d%b h%b want 0 0", done, cpu_hold); end
    repeat (3) step();
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL t5_zero_writes got %0d want 0", wa.size()); end

    do_start(261);
    for (int i = 0; i < 256; i++) send_word(32'h13 | (32'(i) << 16), 0);
    wait_done(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL t5_full_done got %0d want 1", cyc); end
    checks++; if (wa.size() !== 256) begin errors++; $display("FAIL t5_full_nwrites got %0d want 256", wa.size()); end
    if (wa.size() == 256) begin
      seq_bad = 0;
      for (int i = 0; i < 256; i++) if (wa[i] !== AW'(i) || wd[i] !== (32'h13 | (32'(i) << 16))) seq_bad++;
      checks++; if (seq_bad !== 0) begin errors++; $display("FAIL t5_full_seq got %0d bad want 0", seq_bad); end
      checks++; if (wa[255] !== 8'hFF) begin errors++; $display("FAIL t5_last_addr got %0h want ff", wa[255]); end
    end
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL t5_addr_hold got %0h want ff", imem_addr); end
    step();
    checks++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL t5_idle got r%b h%b want 0 0", byte_ready, cpu_hold); end
  endtask

  task automatic test_start_in_load();
    int cyc;
    int d0;
    wa.delete(); wd.delete();
    do_start(2);
    d0 = done_cnt;
    send_byte(8'h6F, 0);
    start     = 1'b1;
    num_words = '0;
    step();
    start     = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_word(32'hA5A5A5A7, 0);
    wait_done(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL t6_done_lat got %0d want 1", cyc); end
    step();
    step();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t6_done_cnt got %0d want 1", done_cnt - d0); end
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL t6_nwrites got %0d want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[0] !== 8'h00 || wa[1] !== 8'h01) begin errors++; $display("FAIL t6_addrs got %0h,%0h want 0,1", wa[0], wa[1]); end
      checks++; if (wd[0] !== 32'h0302016F || wd[1] !== 32'hA5A5A5A7) begin errors++; $display("FAIL t6_data got %0h,%0h want 0302016f,a5a5a5a7", wd[0], wd[1]); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    test_reset();
    test_single_word();
    test_gaps();
    test_err();
    test_reset_mid_load();
    test_bounds();
    test_start_in_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
